// File: rtl/order_book_pkg.sv
// Shared order book types and defaults, used by the arbiter, the update engine
// and the host-side peripheral.
package order_book_pkg;

    localparam int unsigned ORDER_SIZE_DEFAULT = 128;
    localparam int unsigned ADDR_W_DEFAULT     = 7;

    typedef logic [ORDER_SIZE_DEFAULT-1:0] ob_entry_t;
    typedef logic [ADDR_W_DEFAULT-1:0]     ob_addr_t;

    typedef enum logic [1:0] {
        IDLE,
        HOST_RD,
        HOST_CAP,
        HOST_DONE
    } arb_state_t;

endpackage

// File: rtl/ob_prio_grant.sv
// Update-priority grant with a starvation bound: at most MAX_STARVE consecutive
// update grants while a host read waits, then the host is granted.
module ob_prio_grant
    import order_book_pkg::*;
#(
    parameter int unsigned MAX_STARVE = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic i_idle,
    input  logic i_host_req,
    input  logic i_upd_valid,
    output logic o_grant_upd,
    output logic o_grant_host
);

    localparam int unsigned CNT_W = (MAX_STARVE < 1) ? 1 : $clog2(MAX_STARVE + 1);

    logic [CNT_W-1:0] r_starve_cnt;
    logic             w_below;

    assign w_below = 32'(r_starve_cnt) < MAX_STARVE;

    always_comb begin
        o_grant_upd  = i_idle & i_upd_valid & (~i_host_req | w_below);
        o_grant_host = i_idle & i_host_req & ~o_grant_upd;
    end

    // Counts only update grants that bypass a waiting host; w_below makes it saturate.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_starve_cnt <= '0;
        end else if (o_grant_host) begin
            r_starve_cnt <= '0;
        end else if (o_grant_upd && i_host_req && w_below) begin
            r_starve_cnt <= r_starve_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/order_book_mem_arbiter.sv
// Single-port order book RAM arbiter: update writes vs. Avalon-MM host reads.
// Define ORDER_BOOK_STALL_CNT_EN to add the host_stall_cnt output.
module order_book_mem_arbiter
    import order_book_pkg::*;
#(
    parameter int unsigned ORDER_SIZE = ORDER_SIZE_DEFAULT,
    parameter int unsigned ADDR_W     = ADDR_W_DEFAULT,
    parameter int unsigned MAX_STARVE = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  host_chipselect,
    input  logic                  host_read,
    input  logic [ADDR_W-1:0]     host_address,
    output logic [ORDER_SIZE-1:0] host_readdata,
    output logic                  host_waitrequest,
    input  logic                  upd_valid,
    output logic                  upd_ready,
    input  logic [ADDR_W-1:0]     upd_addr,
    input  logic [ORDER_SIZE-1:0] upd_wdata,
    output logic [ADDR_W-1:0]     ram_addr,
    output logic                  ram_we,
    output logic [ORDER_SIZE-1:0] ram_wdata,
    input  logic [ORDER_SIZE-1:0] ram_rdata
`ifdef ORDER_BOOK_STALL_CNT_EN
    ,
    output logic [31:0]           host_stall_cnt
`endif
);

    arb_state_t            r_state;
    arb_state_t            w_state_next;
    logic [ADDR_W-1:0]     r_ram_addr;
    logic                  r_ram_we;
    logic [ORDER_SIZE-1:0] r_ram_wdata;
    logic [ORDER_SIZE-1:0] r_host_readdata;

    logic w_host_req;
    logic w_idle;
    logic w_grant_upd;
    logic w_grant_host;
    logic w_upd_xfer;

    assign w_host_req = host_chipselect & host_read;
    assign w_idle     = (r_state == IDLE);

    ob_prio_grant #(
        .MAX_STARVE (MAX_STARVE)
    ) u_prio_grant (
        .clk          (clk),
        .reset        (reset),
        .i_idle       (w_idle),
        .i_host_req   (w_host_req),
        .i_upd_valid  (upd_valid),
        .o_grant_upd  (w_grant_upd),
        .o_grant_host (w_grant_host)
    );

    // Gated by reset so the handshake is quiet while reset is held.
    assign upd_ready  = reset & w_grant_upd;
    assign w_upd_xfer = upd_valid & upd_ready;

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:      if (w_grant_host) w_state_next = HOST_RD;
            HOST_RD:   w_state_next = HOST_CAP;
            HOST_CAP:  w_state_next = HOST_DONE;
            HOST_DONE: w_state_next = IDLE;
            default:   w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state         <= IDLE;
            r_ram_addr      <= '0;
            r_ram_we        <= 1'b0;
            r_ram_wdata     <= '0;
            r_host_readdata <= '0;
        end else begin
            r_state  <= w_state_next;
            r_ram_we <= w_upd_xfer;
            if (w_upd_xfer) begin
                r_ram_addr  <= upd_addr;
                r_ram_wdata <= upd_wdata;
            end else if (w_grant_host) begin
                r_ram_addr <= host_address;
            end
            // RAM data for the address presented in HOST_RD is valid during HOST_CAP.
            if (r_state == HOST_CAP) begin
                r_host_readdata <= ram_rdata;
            end
        end
    end

    assign ram_addr         = r_ram_addr;
    assign ram_we           = r_ram_we;
    assign ram_wdata        = r_ram_wdata;
    assign host_readdata    = r_host_readdata;
    assign host_waitrequest = (r_state != HOST_DONE);

`ifdef ORDER_BOOK_STALL_CNT_EN
    logic [31:0] r_stall_cnt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_stall_cnt <= '0;
        end else if (w_host_req && host_waitrequest && (r_stall_cnt != 32'hFFFF_FFFF)) begin
            r_stall_cnt <= r_stall_cnt + 32'd1;
        end
    end

    assign host_stall_cnt = r_stall_cnt;
`endif

endmodule

// File: tb/tb_order_book_mem_arbiter.sv
// Randomized bench for order_book_mem_arbiter against a cycle-level reference model.
module tb_order_book_mem_arbiter;

    localparam int unsigned OS = 128;
    localparam int unsigned AW = 7;
    localparam int unsigned MS = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic          host_chipselect, host_read, host_waitrequest;
    logic [AW-1:0] host_address;
    logic [OS-1:0] host_readdata;
    logic          upd_valid, upd_ready;
    logic [AW-1:0] upd_addr;
    logic [OS-1:0] upd_wdata;
    logic [AW-1:0] ram_addr;
    logic          ram_we;
    logic [OS-1:0] ram_wdata, ram_rdata;

    logic          z_cs, z_rd, z_wait, z_uv, z_ready, z_ram_we;
    logic [AW-1:0] z_addr, z_ua, z_ram_addr;
    logic [OS-1:0] z_rdata, z_wd, z_ram_wdata, z_ram_rdata;
`ifdef ORDER_BOOK_STALL_CNT_EN
    logic [31:0]   stall_cnt, z_stall_cnt;
`endif

    always #5 clk = ~clk;

    order_book_mem_arbiter #(.ORDER_SIZE(OS), .ADDR_W(AW), .MAX_STARVE(MS)) dut (
        .clk(clk), .reset(reset),
        .host_chipselect(host_chipselect), .host_read(host_read),
        .host_address(host_address), .host_readdata(host_readdata),
        .host_waitrequest(host_waitrequest),
        .upd_valid(upd_valid), .upd_ready(upd_ready), .upd_addr(upd_addr),
        .upd_wdata(upd_wdata), .ram_addr(ram_addr), .ram_we(ram_we),
        .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
`ifdef ORDER_BOOK_STALL_CNT_EN
        , .host_stall_cnt(stall_cnt)
`endif
    );

    order_book_mem_arbiter #(.ORDER_SIZE(OS), .ADDR_W(AW), .MAX_STARVE(0)) dut0 (
        .clk(clk), .reset(reset),
        .host_chipselect(z_cs), .host_read(z_rd), .host_address(z_addr),
        .host_readdata(z_rdata), .host_waitrequest(z_wait),
        .upd_valid(z_uv), .upd_ready(z_ready), .upd_addr(z_ua), .upd_wdata(z_wd),
        .ram_addr(z_ram_addr), .ram_we(z_ram_we), .ram_wdata(z_ram_wdata),
        .ram_rdata(z_ram_rdata)
`ifdef ORDER_BOOK_STALL_CNT_EN
        , .host_stall_cnt(z_stall_cnt)
`endif
    );

    // Registered-read RAMs with a preload port.
    logic          pl_en;
    logic [AW-1:0] pl_addr;
    logic [OS-1:0] pl_data;
    logic [OS-1:0] ram  [2**AW];
    logic [OS-1:0] ram0 [2**AW];

    always @(posedge clk) begin
        if (pl_en) begin
            ram[pl_addr]  <= pl_data;
            ram0[pl_addr] <= pl_data;
        end else begin
            if (ram_we) ram[ram_addr] <= ram_wdata;
            if (z_ram_we) ram0[z_ram_addr] <= z_ram_wdata;
        end
        ram_rdata   <= ram[ram_addr];
        z_ram_rdata <= ram0[z_ram_addr];
    end

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference model: memory contents in grant order, cycles left in a host sequence.
    logic [OS-1:0] mmem [2**AW];
    int            m_left, m_starve;
    logic [OS-1:0] m_rdata, m_rd_out, m_wdata;
    logic          m_we;
    logic [AW-1:0] m_waddr, m_raddr;
    logic          s_wait, s_ready;

    task automatic model_reset();
        m_left = 0; m_starve = 0; m_rd_out = '0; m_we = 1'b0;
    endtask

    // Check one cycle at the negedge, advance the model, return at posedge+1.
    task automatic step();
        logic hreq, gu;
        @(negedge clk);
        hreq = host_chipselect & host_read;
        gu   = 1'b0;
        if (m_left == 0) begin
            gu = upd_valid & (~hreq | (m_starve < MS));
            chk("upd_ready", 128'(upd_ready), 128'(gu));
            chk("waitreq", 128'(host_waitrequest), 128'(1));
        end else begin
            chk("upd_ready_busy", 128'(upd_ready), 128'(0));
            chk("waitreq_busy", 128'(host_waitrequest), 128'(m_left != 1));
        end
        chk("readdata", host_readdata, m_rd_out);
        chk("ram_we", 128'(ram_we), 128'(m_we));
        if (m_we) begin
            chk("ram_waddr", 128'(ram_addr), 128'(m_waddr));
            chk("ram_wdata", ram_wdata, m_wdata);
        end
        if (m_left == 3) chk("ram_raddr", 128'(ram_addr), 128'(m_raddr));
        s_wait  = host_waitrequest;
        s_ready = upd_ready;
        if (m_left == 2) m_rd_out = m_rdata;
        if (m_left > 0) begin
            m_left--;
            m_we = 1'b0;
        end else if (gu) begin
            mmem[upd_addr] = upd_wdata;
            m_we = 1'b1; m_waddr = upd_addr; m_wdata = upd_wdata;
            if (hreq && m_starve < MS) m_starve++;
        end else if (hreq) begin
            m_left = 3; m_raddr = host_address; m_rdata = mmem[host_address];
            m_starve = 0; m_we = 1'b0;
        end else begin
            m_we = 1'b0;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic host_xfer(input logic [AW-1:0] a, input bit upd_once,
                             output int lat, output int nupd);
        host_chipselect = 1'b1; host_read = 1'b1; host_address = a;
        lat = -1; nupd = 0;
        for (int k = 0; k < 16; k++) begin
            step();
            if (upd_once) upd_valid = 1'b0;
            if (s_ready) nupd++;
            if (!s_wait) begin
                lat = k;
                break;
            end
        end
        host_chipselect = 1'b0; host_read = 1'b0;
    endtask

    int            lat, nupd;
    bit            h_active;
    logic [OS-1:0] z_exp3;
    logic [OS-1:0] pat_a5;

    initial begin
        pat_a5 = {16{8'hA5}};
        reset = 1'b0; pl_en = 1'b1; pl_addr = '0; pl_data = '0;
        host_chipselect = 1'b0; host_read = 1'b0; host_address = '0;
        upd_valid = 1'b1; upd_addr = '0; upd_wdata = '0;
        z_cs = 1'b0; z_rd = 1'b0; z_addr = '0; z_uv = 1'b0; z_ua = '0; z_wd = '0;
        s_wait = 1'b1; s_ready = 1'b0; h_active = 1'b0;
        m_rdata = '0; m_wdata = '0; m_waddr = '0; m_raddr = '0;
        model_reset();
        for (int i = 0; i < 2**AW; i++) begin
            pl_addr = 7'(i);
            pl_data = (i == 5) ? pat_a5 : {$urandom(), $urandom(), $urandom(), $urandom()};
            mmem[i] = pl_data;
            if (i == 3) z_exp3 = pl_data;
            @(posedge clk);
            #1;
        end
        pl_en = 1'b0;

        // Reset values, with an update request present during reset.
        chk("rst_ready", 128'(upd_ready), 128'(0));
        chk("rst_wait", 128'(host_waitrequest), 128'(1));
        chk("rst_rdata", host_readdata, '0);
        chk("rst_ram_we", 128'(ram_we), 128'(0));
        chk("rst_ram_addr", 128'(ram_addr), 128'(0));
        chk("rst_ram_wdata", ram_wdata, '0);
        upd_valid = 1'b0;
        reset = 1'b1;
        step();

        // Idle host read.
        host_xfer(7'h05, 1'b0, lat, nupd);
        chk("idle_rd_lat", 128'(lat), 128'(3));
        chk("idle_rd_data", host_readdata, pat_a5);
        step();
        chk("wait_high_after", 128'(s_wait), 128'(1));

        // Update burst.
        for (int i = 0; i < 3; i++) begin
            upd_valid = 1'b1; upd_addr = 7'(8'h10 + i);
            upd_wdata = {4{32'hC0DE_0000 + 32'(i)}};
            step();
            chk("burst_ready", 128'(s_ready), 128'(1));
        end
        upd_valid = 1'b0;
        step();
        step();

        // Starvation bound, twice to show the counter restarts after a host grant.
        for (int r = 0; r < 2; r++) begin
            upd_valid = 1'b1; upd_addr = 7'(8'h20 + r); upd_wdata = {4{32'h5EED_0000 + 32'(r)}};
            host_xfer(7'(8'h20 + r), 1'b0, lat, nupd);
            upd_valid = 1'b0;
            chk("starve_nupd", 128'(nupd), 128'(MS));
            chk("starve_lat", 128'(lat), 128'(MS + 3));
            chk("starve_data", host_readdata, {4{32'h5EED_0000 + 32'(r)}});
            step();
        end

        // Write and read of the same address requested together: write first.
        upd_valid = 1'b1; upd_addr = 7'h07; upd_wdata = 128'h1234;
        host_xfer(7'h07, 1'b1, lat, nupd);
        chk("raw_nupd", 128'(nupd), 128'(1));
        chk("raw_lat", 128'(lat), 128'(4));
        chk("raw_data", host_readdata, 128'h1234);
        step();

        // Asynchronous reset while the read is in HOST_CAP.
        host_chipselect = 1'b1; host_read = 1'b1; host_address = 7'h05;
        step();
        step();
        reset = 1'b0;
        #1;
        chk("mid_rst_wait", 128'(host_waitrequest), 128'(1));
        chk("mid_rst_rdata", host_readdata, '0);
        chk("mid_rst_ram_addr", 128'(ram_addr), 128'(0));
        chk("mid_rst_ram_we", 128'(ram_we), 128'(0));
        chk("mid_rst_ready", 128'(upd_ready), 128'(0));
        host_chipselect = 1'b0; host_read = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
        reset = 1'b1;
        step();
        host_xfer(7'h05, 1'b0, lat, nupd);
        chk("post_rst_lat", 128'(lat), 128'(3));
        chk("post_rst_data", host_readdata, pat_a5);

        // Random traffic.
        for (int c = 0; c < 600; c++) begin
            if (h_active && !s_wait) h_active = 1'b0;
            if (h_active && $urandom_range(15) == 0) h_active = 1'b0;
            if (!h_active && $urandom_range(3) == 0) begin
                h_active = 1'b1;
                host_address = 7'($urandom());
            end else if (h_active && m_left > 0 && $urandom_range(3) == 0) begin
                host_address = 7'($urandom());
            end
            host_read       = h_active;
            host_chipselect = h_active | ($urandom_range(7) == 0);
            upd_valid = 1'($urandom_range(1));
            upd_addr  = 7'($urandom());
            upd_wdata = {$urandom(), $urandom(), $urandom(), $urandom()};
            step();
        end
        host_chipselect = 1'b0; host_read = 1'b0; upd_valid = 1'b0;
        for (int c = 0; c < 4; c++) step();

        // MAX_STARVE = 0 instance: host wins, update follows after HOST_DONE.
        z_cs = 1'b1; z_rd = 1'b1; z_addr = 7'h03;
        z_uv = 1'b1; z_ua = 7'h09; z_wd = 128'hBEEF;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("z_ready_busy", 128'(z_ready), 128'(0));
            chk("z_wait", 128'(z_wait), 128'(k != 3));
            if (k != 3) begin
                @(posedge clk);
                #1;
            end
        end
        chk("z_rdata", z_rdata, z_exp3);
        @(posedge clk);
        #1;
        z_cs = 1'b0; z_rd = 1'b0;
        @(negedge clk);
        chk("z_ready_after", 128'(z_ready), 128'(1));
        @(posedge clk);
        #1;
        z_uv = 1'b0;
        @(negedge clk);
        chk("z_ram_we", 128'(z_ram_we), 128'(1));
        chk("z_ram_addr", 128'(z_ram_addr), 128'(7'h09));
        chk("z_ram_wdata", z_ram_wdata, 128'hBEEF);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
